huff_sym_decoder: RTL and testbench

- Reader side of the Huffman lookup table that the inflate tree generator fills.
- Accepts the compressed bitstream one bit per cycle and holds a HUFF_CODE_LEN-bit left-aligned lookahead window.
- Indexes the table with the window and returns the decoded symbol and its code length, then discards exactly that many bits.
- Sits between the inflate bit-unpacker and the literal/length/distance handling stage.

---
 rtl/huff_sym_decoder.sv | 136 +++++++++++++
 tb/tb_huff_sym_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_sym_decoder.sv
// Huffman symbol decoder: shifts the bitstream into a left-aligned lookahead window,
// looks it up in an external 1-cycle-latency table and emits (symbol, length) pairs.
module huff_sym_decoder #(
  parameter int HUFF_CODE_LEN = 8,
  parameter int HUFF_LEN_LEN  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     in_bit_i,
  input  logic                     in_valid_i,
  input  logic                     in_last_i,
  output logic                     in_ready_o,
  output logic                     tbl_ren_o,
  output logic [HUFF_CODE_LEN-1:0] tbl_addr_o,
  input  logic [HUFF_CODE_LEN-1:0] tbl_sym_i,
  input  logic [HUFF_LEN_LEN-1:0]  tbl_len_i,
  output logic [HUFF_CODE_LEN-1:0] sym_o,
  output logic [HUFF_LEN_LEN-1:0]  sym_len_o,
  output logic                     sym_valid_o,
  input  logic                     sym_ready_i,
  output logic                     sym_last_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [2:0]               state_o,
  output logic [HUFF_LEN_LEN-1:0]  cnt_o
);

  // Both stream ports use valid/ready: a transfer happens on any rising clk_i edge
  // where valid and ready are both high; valid-side data is held stable until then.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_LOOKUP = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [HUFF_LEN_LEN-1:0] CNT_FULL = HUFF_LEN_LEN'(HUFF_CODE_LEN);
  localparam logic [HUFF_LEN_LEN-1:0] CNT_ONE  = HUFF_LEN_LEN'(1);

  state_t                    state_q, state_d;
  logic [HUFF_CODE_LEN-1:0]  window_q, window_d;
  logic [HUFF_LEN_LEN-1:0]   cnt_q, cnt_d;
  logic                      eos_q, eos_d;
  logic [HUFF_CODE_LEN-1:0]  sym_q, sym_d;
  logic [HUFF_LEN_LEN-1:0]   len_q, len_d;
  logic                      last_q, last_d;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    cnt_d    = cnt_q;
    eos_d    = eos_q;
    sym_d    = sym_q;
    len_d    = len_q;
    last_d   = last_q;
    if (start_i) begin
      window_d = '0;
      cnt_d    = '0;
      eos_d    = 1'b0;
      state_d  = S_FILL;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_FILL: begin
          if (in_valid_i && !eos_q) begin
            // New bits land just below the ones already held, MSB first.
            for (int i = 0; i < HUFF_CODE_LEN; i++) begin
              if (i == HUFF_CODE_LEN - 1 - int'(cnt_q)) window_d[i] = in_bit_i;
            end
            cnt_d = cnt_q + CNT_ONE;
            if (in_last_i) eos_d = 1'b1;
          end
          if (eos_d && cnt_d == '0)              state_d = S_IDLE;
          else if (eos_d || cnt_d == CNT_FULL)   state_d = S_LOOKUP;
        end
        S_LOOKUP: state_d = S_WAIT;
        S_WAIT: begin
          sym_d  = tbl_sym_i;
          len_d  = tbl_len_i;
          last_d = eos_q && (tbl_len_i == cnt_q);
          // A zero length marks an unused entry; a length beyond cnt would eat padding.
          if (tbl_len_i == '0 || tbl_len_i > cnt_q) state_d = S_ERR;
          else                                      state_d = S_EMIT;
        end
        S_EMIT: begin
          if (sym_ready_i) begin
            window_d = window_q << len_q;
            cnt_d    = cnt_q - len_q;
            if (last_q)                     state_d = S_IDLE;
            else if (eos_q && cnt_d != '0)  state_d = S_LOOKUP;
            else                            state_d = S_FILL;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      window_q <= '0;
      cnt_q    <= '0;
      eos_q    <= 1'b0;
      sym_q    <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      eos_q    <= eos_d;
      sym_q    <= sym_d;
      len_q    <= len_d;
      last_q   <= last_d;
    end
  end

  assign in_ready_o  = (state_q == S_FILL) && !eos_q;
  assign tbl_ren_o   = (state_q == S_LOOKUP);
  assign tbl_addr_o  = window_q;
  assign sym_o       = sym_q;
  assign sym_len_o   = len_q;
  assign sym_last_o  = last_q;
  assign sym_valid_o = (state_q == S_EMIT);
  assign err_o       = (state_q == S_ERR);
  assign busy_o      = (state_q != S_IDLE);
  assign state_o     = state_q;
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_huff_sym_decoder.sv
// Bench for huff_sym_decoder: directed scenarios plus random tables/streams checked
// against a queue-based model that decodes the whole stream from the table rules.
module tb_huff_sym_decoder;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FILL = 3'd1, ST_LOOKUP = 3'd2,
                         ST_WAIT = 3'd3, ST_EMIT = 3'd4, ST_ERR = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0;
  logic       in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0, sym_ready = 1'b0;
  logic       in_ready, tbl_ren, sym_valid, sym_last, err, busy;
  logic [7:0] tbl_addr, tbl_sym, sym;
  logic [3:0] tbl_len, sym_len, cnt;
  logic [2:0] state;

  logic [7:0] mem_sym [256];
  logic [3:0] mem_len [256];
  logic       stream  [64];

  logic [12:0] exp_q[$], obs_sym_q[$];
  logic [7:0]  exp_addr_q[$], obs_addr_q[$];
  logic        exp_err, obs_err, timed_out;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  huff_sym_decoder #(.HUFF_CODE_LEN(8), .HUFF_LEN_LEN(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_bit_i(in_bit),
    .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .tbl_ren_o(tbl_ren), .tbl_addr_o(tbl_addr), .tbl_sym_i(tbl_sym),
    .tbl_len_i(tbl_len), .sym_o(sym), .sym_len_o(sym_len),
    .sym_valid_o(sym_valid), .sym_ready_i(sym_ready), .sym_last_o(sym_last),
    .err_o(err), .busy_o(busy), .state_o(state), .cnt_o(cnt)
  );

  // Table memory with a fixed one-cycle read latency.
  always @(posedge clk) begin
    if (tbl_ren) begin
      tbl_sym <= mem_sym[tbl_addr];
      tbl_len <= mem_len[tbl_addr];
    end
  end

  task automatic load_table1();
    for (int a = 0; a < 256; a++) begin
      if (a < 128)      begin mem_sym[a] = 8'h41; mem_len[a] = 4'd1; end
      else if (a < 192) begin mem_sym[a] = 8'h42; mem_len[a] = 4'd2; end
      else              begin mem_sym[a] = 8'h43; mem_len[a] = 4'd2; end
    end
  endtask

  task automatic load_random_table();
    for (int a = 0; a < 256; a++) begin
      mem_sym[a] = 8'($urandom_range(0, 255));
      mem_len[a] = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
    end
  endtask

  // Decode the whole stream (terminated by in_last) straight from the table rules.
  task automatic model(input int n);
    int pos = 0;
    exp_q.delete(); exp_addr_q.delete(); exp_err = 1'b0;
    while (pos < n) begin
      logic [7:0] w;
      int avail, have, len;
      for (int i = 0; i < 8; i++) w[7-i] = (pos + i < n) ? stream[pos+i] : 1'b0;
      avail = n - pos;
      have  = (avail > 8) ? 8 : avail;
      exp_addr_q.push_back(w);
      len = int'(mem_len[w]);
      if (len == 0 || len > have) begin exp_err = 1'b1; break; end
      exp_q.push_back({mem_sym[w], mem_len[w], (len == avail)});
      pos += len;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed_bits(input int n, input logic b);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_bit = b; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0; in_bit = 1'b0;
  endtask

  // Drives stream[0..n-1] (in_last on the final bit) and records lookups and symbols.
  task automatic run_stream(input int n, input int rdy_pct, input bit gaps);
    int pos = 0, cyc = 0;
    obs_sym_q.delete(); obs_addr_q.delete(); obs_err = 1'b0; timed_out = 1'b0;
    pulse_start();
    forever begin
      @(negedge clk);
      cyc++;
      if (tbl_ren) obs_addr_q.push_back(tbl_addr);
      if (err) begin obs_err = 1'b1; break; end
      if (pos == n && !busy) break;
      if (cyc > 3000) begin timed_out = 1'b1; break; end
      in_valid = (pos < n) && (gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_bit   = in_valid ? stream[pos] : 1'b0;
      in_last  = in_valid && (pos == n - 1);
      if (in_valid && in_ready) pos++;
      sym_ready = ($urandom_range(1, 100) <= rdy_pct);
      if (sym_valid && sym_ready) obs_sym_q.push_back({sym, sym_len, sym_last});
    end
    in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0; sym_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({in_ready, tbl_ren, tbl_addr, sym, sym_len, sym_valid, sym_last, err, busy, state, cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b ren=%b addr=%h sym=%h len=%0d v=%b last=%b err=%b busy=%b st=%0d cnt=%0d, want all 0",
               in_ready, tbl_ren, tbl_addr, sym, sym_len, sym_valid, sym_last, err, busy, state, cnt);
    end
  endtask

  task automatic test_decode_padding();
    logic [7:0]  want_addr [3];
    logic [12:0] want_sym  [3];
    want_addr[0] = 8'h58; want_addr[1] = 8'hB0; want_addr[2] = 8'hC0;
    want_sym[0]  = {8'h41, 4'd1, 1'b0};
    want_sym[1]  = {8'h42, 4'd2, 1'b0};
    want_sym[2]  = {8'h43, 4'd2, 1'b1};
    load_table1();
    stream[0] = 0; stream[1] = 1; stream[2] = 0; stream[3] = 1; stream[4] = 1;
    run_stream(5, 100, 1'b0);
    n_checks++;
    if (obs_addr_q.size() != 3 || obs_sym_q.size() != 3 || timed_out || obs_err) begin
      n_fail++;
      $display("FAIL pad_counts: got addrs=%0d syms=%0d to=%b err=%b, want 3 3 0 0",
               obs_addr_q.size(), obs_sym_q.size(), timed_out, obs_err);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_addr_q[i] !== want_addr[i]) begin
          n_fail++; $display("FAIL pad_addr[%0d]: got %h want %h", i, obs_addr_q[i], want_addr[i]);
        end
        n_checks++;
        if (obs_sym_q[i] !== want_sym[i]) begin
          n_fail++; $display("FAIL pad_sym[%0d]: got %h want %h", i, obs_sym_q[i], want_sym[i]);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0 || state !== ST_IDLE) begin
      n_fail++; $display("FAIL pad_idle: got busy=%b state=%0d want 0 0", busy, state);
    end
  endtask

  task automatic test_latency();
    load_table1();
    pulse_start();
    feed_bits(8, 1'b1);
    n_checks++;
    if (tbl_ren !== 1'b1 || tbl_addr !== 8'hFF || sym_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_lookup: got ren=%b addr=%h v=%b want 1 ff 0", tbl_ren, tbl_addr, sym_valid);
    end
    @(negedge clk);
    n_checks++;
    if (sym_valid !== 1'b0 || tbl_ren !== 1'b0) begin
      n_fail++; $display("FAIL lat_wait: got v=%b ren=%b want 0 0", sym_valid, tbl_ren);
    end
    @(negedge clk);
    n_checks++;
    if (sym_valid !== 1'b1 || sym !== 8'h43 || sym_len !== 4'd2 || sym_last !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL lat_emit: got v=%b sym=%h len=%0d last=%b rdy=%b want 1 43 2 0 0",
                         sym_valid, sym, sym_len, sym_last, in_ready);
    end
    sym_ready = 1'b1;
    @(negedge clk);
    sym_ready = 1'b0;
    n_checks++;
    if (state !== ST_FILL || cnt !== 4'd6 || in_ready !== 1'b1 || sym_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_resume: got st=%0d cnt=%0d rdy=%b v=%b want 1 6 1 0", state, cnt, in_ready, sym_valid);
    end
  endtask

  task automatic test_backpressure();
    load_table1();
    pulse_start();
    feed_bits(8, 1'b1);
    @(negedge clk); @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (sym_valid !== 1'b1 || sym !== 8'h43 || sym_len !== 4'd2 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b sym=%h len=%0d rdy=%b want 1 43 2 0",
                           k, sym_valid, sym, sym_len, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    sym_ready = 1'b1;
    @(negedge clk);
    sym_ready = 1'b0;
    n_checks++;
    if (sym_valid !== 1'b0 || cnt !== 4'd6 || state !== ST_FILL) begin
      n_fail++; $display("FAIL bp_release: got v=%b cnt=%0d st=%0d want 0 6 1", sym_valid, cnt, state);
    end
  endtask

  task automatic test_unused_entry();
    load_table1();
    mem_len[0] = 4'd0;
    pulse_start();
    feed_bits(8, 1'b0);
    n_checks++;
    if (tbl_ren !== 1'b1 || tbl_addr !== 8'h00) begin
      n_fail++; $display("FAIL unused_lookup: got ren=%b addr=%h want 1 00", tbl_ren, tbl_addr);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL unused_wait_err: got err=%b want 0", err);
    end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || sym_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL unused_sticky[%0d]: got err=%b v=%b rdy=%b want 1 0 0", k, err, sym_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    n_checks++;
    if (err !== 1'b0 || in_ready !== 1'b1 || cnt !== 4'd0) begin
      n_fail++; $display("FAIL unused_clear: got err=%b rdy=%b cnt=%0d want 0 1 0", err, in_ready, cnt);
    end
  endtask

  task automatic test_short_tail();
    load_table1();
    mem_sym[8'h80] = 8'h42; mem_len[8'h80] = 4'd2;
    stream[0] = 1;
    run_stream(1, 100, 1'b0);
    n_checks++;
    if (obs_err !== 1'b1 || obs_sym_q.size() != 0 || timed_out) begin
      n_fail++; $display("FAIL tail_err: got err=%b syms=%0d to=%b want 1 0 0", obs_err, obs_sym_q.size(), timed_out);
    end
    n_checks++;
    if (obs_addr_q.size() != 1 || obs_addr_q[0] !== 8'h80) begin
      n_fail++; $display("FAIL tail_addr: got n=%0d want one lookup at 80", obs_addr_q.size());
    end
  endtask

  task automatic test_interrupts();
    load_table1();
    pulse_start();
    feed_bits(8, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({in_ready, tbl_ren, tbl_addr, sym, sym_len, sym_valid, sym_last, err, busy, state} !== '0) begin
      n_fail++; $display("FAIL int_rst_emit: got v=%b busy=%b st=%0d sym=%h want all 0", sym_valid, busy, state, sym);
    end
    pulse_start();
    feed_bits(8, 1'b1);
    @(negedge clk);
    n_checks++;
    if (state !== ST_WAIT) begin
      n_fail++; $display("FAIL int_reach_wait: got st=%0d want %0d", state, ST_WAIT);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (state !== ST_FILL || cnt !== 4'd0 || sym_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL int_start_wait[%0d]: got st=%0d cnt=%0d v=%b rdy=%b want 1 0 0 1",
                           k, state, cnt, sym_valid, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(1, 40);
      load_random_table();
      for (int i = 0; i < n; i++) stream[i] = 1'($urandom_range(0, 1));
      model(n);
      run_stream(n, $urandom_range(25, 100), 1'b1);
      n_checks++;
      if (timed_out || obs_err !== exp_err || obs_sym_q.size() != exp_q.size() || obs_addr_q.size() != exp_addr_q.size()) begin
        n_fail++; $display("FAIL rand_shape[%0d]: got to=%b err=%b syms=%0d addrs=%0d want 0 %b %0d %0d",
                           it, timed_out, obs_err, obs_sym_q.size(), obs_addr_q.size(), exp_err, exp_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_checks++;
          if (obs_sym_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL rand_sym[%0d.%0d]: got %h want %h", it, i, obs_sym_q[i], exp_q[i]);
          end
        end
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          n_checks++;
          if (obs_addr_q[i] !== exp_addr_q[i]) begin
            n_fail++; $display("FAIL rand_addr[%0d.%0d]: got %h want %h", it, i, obs_addr_q[i], exp_addr_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_padding();
    test_latency();
    test_backpressure();
    test_unused_entry();
    test_short_tail();
    test_interrupts();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
